fetch_unit: RTL

- Instruction-fetch stage directly upstream of the control decoder.
- Holds the program counter, addresses the instruction ROM, and forwards the 9-bit machine word as mach_code.
- Owns the mode flip-flop: it registers the decoder's next-mode result and drives it back as modeQ.
- Also provides start/halt sequencing, taken-branch redirection through a small jump-target LUT, stall hold, and a retired-instruction counter.

---
 rtl/isa_pkg.sv | 40 ++++
 rtl/fetch_unit_if.sv | 34 +++
 rtl/jump_lut.sv | 16 +
 rtl/fetch_unit.sv | 88 ++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared ISA constants, fetch state type and jump-target table
//
// Purpose: definitions shared by the fetch stage, its sub-modules and the
// assembler tooling.
// Ports: none (package).
package isa_pkg;

    localparam int PC_W      = 10;
    localparam int INSTR_W   = 9;
    localparam int LUT_IDX_W = 3;
    localparam int CNT_W     = 16;

    localparam logic MODE_REG = 1'b0;
    localparam logic MODE_IMM = 1'b1;

    localparam logic [INSTR_W-1:0] HALT_CODE = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // Branch targets; the assembler resolves jump labels against this same table.
    function automatic logic [PC_W-1:0] jump_target(input logic [LUT_IDX_W-1:0] idx);
        logic [PC_W-1:0] target;
        case (idx)
            3'd0:    target = 10'd16;
            3'd1:    target = 10'd24;
            3'd2:    target = 10'd32;
            3'd3:    target = 10'd40;
            3'd4:    target = 10'd100;
            3'd5:    target = 10'd512;
            3'd6:    target = 10'd1000;
            default: target = 10'd1023;
        endcase
        return target;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - control/ROM side signal bundle of the fetch stage
//
// Purpose: groups the fetch stage's control inputs, ROM port and outputs.
// Modports:
//   slave  - the fetch unit: receives control + rom_data, drives rom_addr,
//            mach_code, modeQ, instr_valid, done, instr_count.
//   master - the surrounding control/ROM logic (opposite directions).
interface fetch_unit_if;
    import isa_pkg::*;

    logic                 start;
    logic                 stall;
    logic                 halt_req;
    logic                 branch_taken;
    logic [LUT_IDX_W-1:0] branch_idx;
    logic                 mode_next;
    logic [INSTR_W-1:0]   rom_data;
    logic [PC_W-1:0]      rom_addr;
    logic [INSTR_W-1:0]   mach_code;
    logic                 modeQ;
    logic                 instr_valid;
    logic                 done;
    logic [CNT_W-1:0]     instr_count;

    modport slave (
        input  start, stall, halt_req, branch_taken, branch_idx, mode_next, rom_data,
        output rom_addr, mach_code, modeQ, instr_valid, done, instr_count
    );

    modport master (
        output start, stall, halt_req, branch_taken, branch_idx, mode_next, rom_data,
        input  rom_addr, mach_code, modeQ, instr_valid, done, instr_count
    );
endinterface

// File: rtl/jump_lut.sv
// rtl/jump_lut.sv - combinational branch-target lookup
//
// Purpose: maps a jump-LUT index to a fixed program counter target.
// Ports:
//   idx    in  LUT_IDX_W  table index
//   target out PC_W       branch target address
module jump_lut
    import isa_pkg::*;
(
    input  logic [LUT_IDX_W-1:0] idx,
    output logic [PC_W-1:0]      target
);

    assign target = jump_target(idx);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with start/halt sequencing
//
// Purpose: holds the program counter, addresses the instruction ROM, forwards
// the machine word, registers the decoder's mode and counts retired
// instructions.
// Ports:
//   clk    in  system clock, all updates on posedge
//   reset  in  synchronous active-high reset
//   bus    fetch_unit_if.slave (control inputs, ROM port, status outputs)
module fetch_unit
    import isa_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.slave  bus
);

    fetch_state_t         state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic                 mode_q, mode_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PC_W-1:0]      lut_target;
    logic [CNT_W-1:0]     count_inc;

    jump_lut u_jump_lut (
        .idx    (bus.branch_idx),
        .target (lut_target)
    );

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    assign count_inc = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            mode_q  <= MODE_REG;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mode_q  <= mode_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mode_d  = mode_q;
        count_d = count_q;
        case (state_q)
            IDLE, HALT: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    mode_d  = MODE_REG;
                    count_d = '0;
                end
            end
            RUN: begin
                // A stalled cycle leaves all state untouched; otherwise the
                // current instruction retires with halt > branch > sequential.
                if (!bus.stall) begin
                    count_d = count_inc;
                    if (bus.halt_req) begin
                        state_d = HALT;
                    end else if (bus.branch_taken) begin
                        pc_d   = lut_target;
                        mode_d = bus.mode_next;
                    end else begin
                        pc_d   = pc_q + PC_W'(1);
                        mode_d = bus.mode_next;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rom_addr    = pc_q;
    assign bus.mach_code   = (state_q == RUN) ? bus.rom_data : '0;
    assign bus.modeQ       = mode_q;
    assign bus.instr_valid = (state_q == RUN) && !bus.stall;
    assign bus.done        = (state_q == HALT);
    assign bus.instr_count = count_q;

endmodule
